fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the instruction controller. It walks a program counter through a synchronous-read instruction memory and captures each 32-bit word into an instruction register. It presents that word to the controller over a valid/ready handshake. It also redirects on a taken branch and stops on the reserved HALT opcode.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_perf_cnt.sv | 44 ++++
 rtl/fetch_unit.sv | 140 ++++++++++++++
 tb/tb_fetch_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Opcode position constants are also used by the downstream controller.
package fetch_pkg;

    // Fetch sequencer states.
    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StHold,
        StHalted
    } fetch_state_e;

    // Opcode occupies the top OPCODE_W bits of every instruction word.
    localparam int unsigned OPCODE_W = 4;

    // Reserved opcode that stops fetching.
    localparam logic [OPCODE_W-1:0] HALT_OPCODE = 4'hF;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Saturating performance counters for the fetch stage: accepted
// handshakes and HOLD cycles stalled on the controller.
// Only instantiated when FETCH_PERF_CNT_EN is defined.
module fetch_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        fetched_i,
    input  logic        stall_i,
    output logic [31:0] perf_fetched_o,
    output logic [31:0] perf_stalls_o
);

    logic [31:0] fetched_q, fetched_d;
    logic [31:0] stalls_q, stalls_d;

    // Next-state: clear wins, otherwise count up and stick at all-ones.
    always_comb begin
        fetched_d = fetched_q;
        stalls_d  = stalls_q;
        if (clear_i) begin
            fetched_d = '0;
            stalls_d  = '0;
        end else begin
            if (fetched_i && (fetched_q != '1)) fetched_d = fetched_q + 32'd1;
            if (stall_i && (stalls_q != '1))    stalls_d  = stalls_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetched_q <= '0;
            stalls_q  <= '0;
        end else begin
            fetched_q <= fetched_d;
            stalls_q  <= stalls_d;
        end
    end

    assign perf_fetched_o = fetched_q;
    assign perf_stalls_o  = stalls_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: walks a PC through a synchronous-read
// instruction memory, holds each word for the controller over a
// valid/ready handshake, redirects on branch and stops on HALT.
// Optional feature macro: FETCH_PERF_CNT_EN adds perf_fetched/perf_stalls.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 10,
    parameter int unsigned       INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               branch_take,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               busy,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stalls,
`endif
    output logic               done
);

    fetch_state_e        state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
    logic                done_q, done_d;

    logic [OPCODE_W-1:0] opcode;
    logic                start_go;
    logic                accept;
    logic [ADDR_W-1:0]   pc_inc;

    assign opcode   = imem_rdata[INSTR_W-1 -: OPCODE_W];
    assign start_go = start && ((state_q == StIdle) || (state_q == StHalted));
    assign accept   = (state_q == StHold) && instr_ready;
    // Natural wrap at 2^ADDR_W.
    assign pc_inc   = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};

    // Next-state logic for the fetch sequencer, PC and instruction register.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        done_d     = 1'b0;
        unique case (state_q)
            StIdle, StHalted: begin
                if (start_go) begin
                    pc_d    = RESET_PC;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                // A redirect here simply abandons the read just issued.
                if (branch_take) begin
                    pc_d    = branch_target;
                    state_d = StFetch;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (branch_take) begin
                    // Drop the returning word without inspecting it for HALT.
                    pc_d    = branch_target;
                    state_d = StFetch;
                end else if (opcode == HALT_OPCODE) begin
                    done_d  = 1'b1;
                    state_d = StHalted;
                end else begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    state_d    = StHold;
                end
            end
            StHold: begin
                // Branch target takes priority over PC+1 even when accepted.
                if (branch_take) begin
                    pc_d    = branch_target;
                    state_d = StFetch;
                end else if (accept) begin
                    pc_d    = pc_inc;
                    state_d = StFetch;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset forces IDLE immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= RESET_PC;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            done_q     <= done_d;
        end
    end

    // Outputs come from registers or state decode only.
    assign imem_en     = (state_q == StFetch);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = (state_q == StHold);
    assign busy        = (state_q == StFetch) || (state_q == StWait) || (state_q == StHold);
    assign done        = done_q;

`ifdef FETCH_PERF_CNT_EN
    fetch_perf_cnt u_perf_cnt (
        .clk            (clk),
        .rst            (rst),
        .clear_i        (start_go),
        .fetched_i      (accept),
        .stall_i        ((state_q == StHold) && !instr_ready),
        .perf_fetched_o (perf_fetched),
        .perf_stalls_o  (perf_stalls)
    );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a synchronous-read
// instruction memory model. Inputs change and outputs are sampled on
// the falling edge.
module tb_fetch_unit;

    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned INSTR_W = 32;

    logic               clk;
    logic               rst;
    logic               start;
    logic               imem_en;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ready;
    logic [ADDR_W-1:0]  instr_pc;
    logic               branch_take;
    logic [ADDR_W-1:0]  branch_target;
    logic               busy;
    logic               done;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]        perf_fetched;
    logic [31:0]        perf_stalls;
`endif

    int checks   = 0;
    int failures = 0;

    logic [INSTR_W-1:0] mem [0:(1<<ADDR_W)-1];

    fetch_unit #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .RESET_PC (10'h000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .imem_en       (imem_en),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_pc      (instr_pc),
        .branch_take   (branch_take),
        .branch_target (branch_target),
        .busy          (busy),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched  (perf_fetched),
        .perf_stalls   (perf_stalls),
`endif
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory: data valid the cycle after imem_en.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b0;
        instr_ready = 1'b0;
        branch_take = 1'b0;
        branch_target = '0;
        tick();
        chk("rst_imem_en", 64'(imem_en), 64'd0);
        chk("rst_imem_addr", 64'(imem_addr), 64'h000);
        chk("rst_instr", 64'(instr), 64'd0);
        chk("rst_instr_valid", 64'(instr_valid), 64'd0);
        chk("rst_instr_pc", 64'(instr_pc), 64'h000);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst = 1'b1;
        tick();
        chk("idle_busy", 64'(busy), 64'd0);
    endtask

    task automatic test_basic_run();
        start = 1'b1;
        instr_ready = 1'b1;
        tick();                                   // edge 0 -> FETCH
        start = 1'b0;
        chk("run_fetch0_en", 64'(imem_en), 64'd1);
        chk("run_fetch0_addr", 64'(imem_addr), 64'h000);
        chk("run_fetch0_busy", 64'(busy), 64'd1);
        tick();                                   // WAIT
        chk("run_wait0_en", 64'(imem_en), 64'd0);
        chk("run_wait0_valid", 64'(instr_valid), 64'd0);
        tick();                                   // HOLD
        chk("run_hold0_valid", 64'(instr_valid), 64'd1);
        chk("run_hold0_instr", 64'(instr), 64'h1123_0000);
        chk("run_hold0_pc", 64'(instr_pc), 64'h000);
        tick();                                   // accepted -> FETCH 1
        chk("run_fetch1_addr", 64'(imem_addr), 64'h001);
        chk("run_fetch1_valid", 64'(instr_valid), 64'd0);
        tick();
        tick();
        chk("run_hold1_valid", 64'(instr_valid), 64'd1);
        chk("run_hold1_instr", 64'(instr), 64'h0456_0000);
        chk("run_hold1_pc", 64'(instr_pc), 64'h001);
        tick();                                   // FETCH 2 (HALT word)
        chk("run_fetch2_addr", 64'(imem_addr), 64'h002);
        tick();                                   // WAIT
        tick();                                   // first HALTED cycle
        chk("halt_done", 64'(done), 64'd1);
        chk("halt_busy", 64'(busy), 64'd0);
        chk("halt_valid", 64'(instr_valid), 64'd0);
        tick();
        chk("halt_done_pulse", 64'(done), 64'd0);
        chk("halt_stay_en", 64'(imem_en), 64'd0);
        chk("halt_instr_kept", 64'(instr), 64'h0456_0000);
    endtask

    task automatic test_stall();
        instr_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();                                   // HOLD at PC 0
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 64'(instr_valid), 64'd1);
            chk("stall_instr", 64'(instr), 64'h1123_0000);
            chk("stall_pc", 64'(instr_pc), 64'h000);
            chk("stall_no_en", 64'(imem_en), 64'd0);
            tick();
        end
        chk("stall_still_hold", 64'(instr_valid), 64'd1);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_stalls_5", 64'(perf_stalls), 64'd5);
        chk("perf_fetched_clr", 64'(perf_fetched), 64'd0);
`endif
        instr_ready = 1'b1;
        tick();                                   // accept -> FETCH 1
        chk("stall_release_addr", 64'(imem_addr), 64'h001);
        chk("stall_release_en", 64'(imem_en), 64'd1);
    endtask

    task automatic test_branch_wait();
        tick();
        tick();                                   // HOLD at PC 1
        tick();                                   // accept -> FETCH 2
        tick();                                   // WAIT with HALT word returning
        branch_take = 1'b1;
        branch_target = 10'h040;
        tick();
        branch_take = 1'b0;
        chk("brw_en", 64'(imem_en), 64'd1);
        chk("brw_addr", 64'(imem_addr), 64'h040);
        chk("brw_no_done", 64'(done), 64'd0);
        chk("brw_busy", 64'(busy), 64'd1);
        tick();
        tick();
        chk("brw_valid", 64'(instr_valid), 64'd1);
        chk("brw_instr", 64'(instr), 64'h2000_0040);
        chk("brw_pc", 64'(instr_pc), 64'h040);
    endtask

    task automatic test_branch_accept();
        // Branch out of HOLD without accepting, to land at PC 5.
        instr_ready = 1'b0;
        branch_take = 1'b1;
        branch_target = 10'h005;
        tick();
        branch_take = 1'b0;
        chk("brh_addr", 64'(imem_addr), 64'h005);
        chk("brh_valid_drop", 64'(instr_valid), 64'd0);
        tick();
        tick();
        chk("bra_pc5", 64'(instr_pc), 64'h005);
        chk("bra_instr5", 64'(instr), 64'h2000_0005);
        instr_ready = 1'b1;
        branch_take = 1'b1;
        branch_target = 10'h010;
        tick();
        branch_take = 1'b0;
        chk("bra_addr", 64'(imem_addr), 64'h010);
        chk("bra_en", 64'(imem_en), 64'd1);
`ifdef FETCH_PERF_CNT_EN
        chk("bra_perf_fetched", 64'(perf_fetched), 64'd3);
        chk("bra_perf_stalls", 64'(perf_stalls), 64'd6);
`endif
    endtask

    task automatic test_wrap();
        // Redirect during FETCH straight to the last word.
        branch_take = 1'b1;
        branch_target = 10'h3FF;
        tick();
        branch_take = 1'b0;
        chk("wrap_fetch_addr", 64'(imem_addr), 64'h3FF);
        tick();
        tick();
        chk("wrap_pc", 64'(instr_pc), 64'h3FF);
        chk("wrap_instr", 64'(instr), 64'h2000_03FF);
        tick();
        chk("wrap_next_addr", 64'(imem_addr), 64'h000);
        chk("wrap_next_en", 64'(imem_en), 64'd1);
    endtask

    task automatic test_async_reset();
        instr_ready = 1'b0;
        tick();
        tick();                                   // HOLD at PC 0
        chk("ar_pre_valid", 64'(instr_valid), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_valid", 64'(instr_valid), 64'd0);
        chk("ar_en", 64'(imem_en), 64'd0);
        chk("ar_busy", 64'(busy), 64'd0);
        chk("ar_instr", 64'(instr), 64'd0);
        tick();
        rst = 1'b1;
        branch_take = 1'b1;
        branch_target = 10'h020;
        tick();
        branch_take = 1'b0;
        chk("idle_ignore_branch_en", 64'(imem_en), 64'd0);
        chk("idle_ignore_branch_busy", 64'(busy), 64'd0);
        chk("idle_ignore_branch_addr", 64'(imem_addr), 64'h000);
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h2000_0000 | i;
        mem[0] = 32'h1123_0000;
        mem[1] = 32'h0456_0000;
        mem[2] = 32'hF000_0000;
        imem_rdata = '0;
        test_reset();
        test_basic_run();
        test_stall();
        test_branch_wait();
        test_branch_accept();
        test_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
